// File: rtl/wake_ctrl_pkg.sv
// Shared types for the core wake/reset controller: wake policy and FSM states.
package wake_ctrl_pkg;

    typedef enum logic [1:0] {
        WAKE_COUNT,
        WAKE_EVENT,
        WAKE_BOTH
    } wake_mode_e;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_RUN,
        ST_SWRST
    } wake_state_e;

endpackage

// File: rtl/core_wake_rst_ctrl_if.sv
// Tile-side bundle of the core wake/reset controller: wake/reset requests, raw and conditioned interrupts.
interface core_wake_rst_ctrl_if #(
    parameter int NrIrq = 2
);
    logic             wake_evt_i;
    logic             sw_rst_i;
    logic [NrIrq-1:0] irq_i;
    logic             ipi_i;
    logic             time_irq_i;
    logic             debug_req_i;
    logic             core_rst_no;
    logic [NrIrq-1:0] irq_o;
    logic             ipi_o;
    logic             time_irq_o;
    logic             debug_req_o;
    logic             awake_o;

    modport slave (
        input  wake_evt_i, sw_rst_i, irq_i, ipi_i, time_irq_i, debug_req_i,
        output core_rst_no, irq_o, ipi_o, time_irq_o, debug_req_o, awake_o
    );

    modport master (
        output wake_evt_i, sw_rst_i, irq_i, ipi_i, time_irq_i, debug_req_i,
        input  core_rst_no, irq_o, ipi_o, time_irq_o, debug_req_o, awake_o
    );
endinterface

// File: rtl/sync_chain.sv
// Single-bit flop synchroniser with asynchronous active-low clear.
module sync_chain #(
    parameter int Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [Stages-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_q <= '0;
        else         r_q <= {r_q[Stages-2:0], d_i};
    end

    assign q_o = r_q[Stages-1];
endmodule

// File: rtl/core_wake_rst_ctrl.sv
// Holds the Ariane core in reset until tile SRAMs are initialised, handles software core
// reset with a minimum length, and synchronises/masks the core's interrupt inputs.
module core_wake_rst_ctrl
    import wake_ctrl_pkg::*;
#(
    parameter int         WakeCntWidth   = 16,
    parameter wake_mode_e WakeMode       = WAKE_COUNT,
    parameter int         SyncStages     = 2,
    parameter int         NrIrq          = 2,
    parameter int         MinSwRstCycles = 16
) (
    input  logic clk_i,
    input  logic reset_l,
    core_wake_rst_ctrl_if.slave io
);
    localparam int NLines = NrIrq + 3;
    localparam int SwW    = $clog2(MinSwRstCycles + 1);

    initial begin : p_param_chk
        assert (WakeCntWidth >= 2)   else $error("WakeCntWidth must be >= 2");
        assert (SyncStages >= 2)     else $error("SyncStages must be >= 2");
        assert (MinSwRstCycles >= 1) else $error("MinSwRstCycles must be >= 1");
    end

    wake_state_e             r_state, w_state_nxt;
    logic [WakeCntWidth-1:0] r_wcnt, w_wcnt_inc;
    logic [SwW-1:0]          r_scnt, w_scnt_inc;
    logic                    r_evt_seen;
    logic                    w_evt, w_wake_done, w_sw_done, w_gate, w_core_rst_n;
    logic [NLines-1:0]       w_raw, w_sync;

    // Done conditions look at the post-increment count so the transition lands on the
    // edge where the count is reached, not one edge later.
    assign w_wcnt_inc = r_wcnt[WakeCntWidth-1] ? r_wcnt : r_wcnt + WakeCntWidth'(1);
    assign w_scnt_inc = (r_scnt == SwW'(MinSwRstCycles)) ? r_scnt : r_scnt + SwW'(1);
    assign w_evt      = r_evt_seen | io.wake_evt_i;
    assign w_sw_done  = (w_scnt_inc == SwW'(MinSwRstCycles)) && !io.sw_rst_i;

    always_comb begin
        case (WakeMode)
            WAKE_EVENT: w_wake_done = w_evt;
            WAKE_BOTH:  w_wake_done = w_wcnt_inc[WakeCntWidth-1] && w_evt;
            default:    w_wake_done = w_wcnt_inc[WakeCntWidth-1];
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= ST_WAIT;
            r_wcnt     <= '0;
            r_evt_seen <= 1'b0;
            r_scnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_WAIT) begin
                r_wcnt     <= w_wcnt_inc;
                r_evt_seen <= w_evt;
            end
            r_scnt <= (r_state == ST_SWRST) ? w_scnt_inc : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT:  if (w_wake_done)    w_state_nxt = ST_RUN;
            ST_RUN:   if (io.sw_rst_i)    w_state_nxt = ST_SWRST;
            ST_SWRST: if (w_sw_done)      w_state_nxt = ST_RUN;
            default:                      w_state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        w_gate = (r_state == ST_RUN);
    end

    assign io.awake_o = w_gate;

    // Reset path: asserts with reset_l, releases SyncStages edges after the gate rises.
    sync_chain #(.Stages(SyncStages)) u_rst_sync (
        .clk_i (clk_i),
        .rst_ni(reset_l),
        .d_i   (w_gate),
        .q_o   (w_core_rst_n)
    );

    assign w_raw = {io.debug_req_i, io.time_irq_i, io.ipi_i, io.irq_i};

    for (genvar g = 0; g < NLines; g++) begin : g_line
        sync_chain #(.Stages(SyncStages)) u_sync (
            .clk_i (clk_i),
            .rst_ni(reset_l),
            .d_i   (w_raw[g]),
            .q_o   (w_sync[g])
        );
    end

    assign io.core_rst_no = w_core_rst_n;
    assign io.irq_o       = w_sync[NrIrq-1:0] & {NrIrq{w_core_rst_n}};
    assign io.ipi_o       = w_sync[NrIrq]   & w_core_rst_n;
    assign io.time_irq_o  = w_sync[NrIrq+1] & w_core_rst_n;
    assign io.debug_req_o = w_sync[NrIrq+2] & w_core_rst_n;
endmodule

// File: tb/tb_core_wake_rst_ctrl.sv
// Randomised bench for core_wake_rst_ctrl: three wake policies side by side, checked
// against an edge-counting reference model.
module tb_core_wake_rst_ctrl;
    import wake_ctrl_pkg::*;

    localparam int NrIrq = 2;
    localparam int W     = 4;
    localparam int SAT   = 8;
    localparam int NI    = 3;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    logic       evt[NI];
    logic       sw[NI];
    logic [4:0] raw;
    logic [6:0] outs[NI];

    core_wake_rst_ctrl_if #(.NrIrq(NrIrq)) if0 ();
    core_wake_rst_ctrl_if #(.NrIrq(NrIrq)) if1 ();
    core_wake_rst_ctrl_if #(.NrIrq(NrIrq)) if2 ();

    assign if0.wake_evt_i = evt[0];
    assign if0.sw_rst_i = sw[0];
    assign if0.irq_i = raw[1:0];
    assign if0.ipi_i = raw[2];
    assign if0.time_irq_i = raw[3];
    assign if0.debug_req_i = raw[4];
    assign if1.wake_evt_i = evt[1];
    assign if1.sw_rst_i = sw[1];
    assign if1.irq_i = raw[1:0];
    assign if1.ipi_i = raw[2];
    assign if1.time_irq_i = raw[3];
    assign if1.debug_req_i = raw[4];
    assign if2.wake_evt_i = evt[2];
    assign if2.sw_rst_i = sw[2];
    assign if2.irq_i = raw[1:0];
    assign if2.ipi_i = raw[2];
    assign if2.time_irq_i = raw[3];
    assign if2.debug_req_i = raw[4];

    assign outs[0] = {if0.awake_o, if0.core_rst_no, if0.debug_req_o, if0.time_irq_o, if0.ipi_o, if0.irq_o};
    assign outs[1] = {if1.awake_o, if1.core_rst_no, if1.debug_req_o, if1.time_irq_o, if1.ipi_o, if1.irq_o};
    assign outs[2] = {if2.awake_o, if2.core_rst_no, if2.debug_req_o, if2.time_irq_o, if2.ipi_o, if2.irq_o};

    core_wake_rst_ctrl #(.WakeCntWidth(W), .WakeMode(WAKE_COUNT), .SyncStages(2),
                         .NrIrq(NrIrq), .MinSwRstCycles(4)) u_cnt (
        .clk_i(clk), .reset_l(reset_l), .io(if0));
    core_wake_rst_ctrl #(.WakeCntWidth(W), .WakeMode(WAKE_EVENT), .SyncStages(2),
                         .NrIrq(NrIrq), .MinSwRstCycles(4)) u_evt (
        .clk_i(clk), .reset_l(reset_l), .io(if1));
    core_wake_rst_ctrl #(.WakeCntWidth(W), .WakeMode(WAKE_BOTH), .SyncStages(3),
                         .NrIrq(NrIrq), .MinSwRstCycles(5)) u_both (
        .clk_i(clk), .reset_l(reset_l), .io(if2));

    // Model: edge number since reset, first-wake rules per mode, and output histories.
    int   ss_a[NI]  = '{2, 2, 3};
    int   min_a[NI] = '{4, 4, 5};
    int   mode_a[NI] = '{0, 1, 2};
    int   n[NI];
    int   sw_start[NI];
    int   hold[NI];
    bit   awake[NI], in_sw[NI], seen[NI];
    bit   g_hist[NI][8];
    logic [4:0] in_hist[8];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ee;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            n[i] = 0; awake[i] = 0; in_sw[i] = 0; seen[i] = 0; sw_start[i] = 0;
            for (int k = 0; k < 8; k++) g_hist[i][k] = 0;
        end
        for (int k = 0; k < 8; k++) in_hist[k] = '0;
    endtask

    task automatic model_step();
        bit done;
        for (int k = 7; k > 0; k--) in_hist[k] = in_hist[k-1];
        in_hist[0] = raw;
        for (int i = 0; i < NI; i++) begin
            n[i]++;
            if (!awake[i] && !in_sw[i]) begin
                seen[i] = seen[i] | evt[i];
                case (mode_a[i])
                    0:       done = (n[i] >= SAT);
                    1:       done = seen[i];
                    default: done = seen[i] && (n[i] >= SAT);
                endcase
                if (done) awake[i] = 1;
            end else if (awake[i]) begin
                if (sw[i]) begin awake[i] = 0; in_sw[i] = 1; sw_start[i] = n[i]; end
            end else if ((n[i] - sw_start[i] >= min_a[i]) && !sw[i]) begin
                in_sw[i] = 0; awake[i] = 1;
            end
            for (int k = 7; k > 0; k--) g_hist[i][k] = g_hist[i][k-1];
            g_hist[i][0] = awake[i];
        end
    endtask

    function automatic logic [6:0] exp_out(input int i);
        logic r;
        r = g_hist[i][ss_a[i]];
        return {awake[i], r, in_hist[ss_a[i]-1] & {5{r}}};
    endfunction

    task automatic check_all(input string ph);
        logic [6:0] e;
        for (int i = 0; i < NI; i++) begin
            e = exp_out(i);
            chk($sformatf("%s.i%0d.n%0d.awake", ph, i, n[i]), 32'(outs[i][6]), 32'(e[6]));
            chk($sformatf("%s.i%0d.n%0d.core_rst_no", ph, i, n[i]), 32'(outs[i][5]), 32'(e[5]));
            chk($sformatf("%s.i%0d.n%0d.irqs", ph, i, n[i]), 32'(outs[i][4:0]), 32'(e[4:0]));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            evt[i] = (n[i] + 1 == ee) || ((n[i] + 1 > ee) && ($urandom_range(0, 9) == 0));
            if (hold[i] > 0) begin
                sw[i] = 1; hold[i]--;
            end else if ($urandom_range(0, 11) == 0) begin
                sw[i] = 1; hold[i] = $urandom_range(0, 9);
            end else begin
                sw[i] = 0;
            end
        end
        raw = raw ^ 5'($urandom & $urandom);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin evt[i] = 0; sw[i] = 0; hold[i] = 0; end
        raw = '0;
        ee = 0;
        model_reset();
        for (int ep = 0; ep < 8; ep++) begin
            reset_l = 1'b0;
            for (int i = 0; i < NI; i++) evt[i] = 0;
            repeat (3) begin
                @(posedge clk);
                model_reset();
                @(negedge clk);
                check_all("rst");
            end
            case (ep % 4)
                0:       ee = 3;
                1:       ee = SAT;
                2:       ee = 12;
                default: ee = $urandom_range(2, 14);
            endcase
            reset_l = 1'b1;
            drive();
            for (int c = 0; c < 70; c++) begin
                @(posedge clk);
                model_step();
                @(negedge clk);
                check_all("run");
                drive();
            end
            reset_l = 1'b0;
            #1;
            model_reset();
            check_all("async");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
